// File: rtl/ascon_aead128_pkg.sv
`default_nettype none
// ascon_aead128_pkg: shared Ascon state/round types, round-count constants and engine FSM encoding.
// Rev 1.0
package ascon_aead128_pkg;

    typedef logic [319:0] ascon_state;
    typedef logic [3:0]   ascon_rnd;

    localparam int ROUNDS_A   = 12;
    localparam int ROUNDS_B   = 8;
    localparam int ROUND_LAST = 11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} engine_fsm;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round_engine_if.sv
`default_nettype none
// ascon_round_engine_if: request/response valid-ready bundle between mode controller and round engine.
// Rev 1.0
interface ascon_round_engine_if;
    import ascon_aead128_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       pb_sel;
    ascon_state state_in;
    logic       out_valid;
    logic       out_ready;
    ascon_state state_out;

    modport master (
        output in_valid, pb_sel, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, pb_sel, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface
`default_nettype wire

// File: rtl/ascon_round_engine_perm.sv
`default_nettype none
// ascon_round_engine_perm: one combinational Ascon round (constant add, 5-bit S-box, linear diffusion).
// Rev 1.0
module ascon_round_engine_perm
    import ascon_aead128_pkg::*;
(
    input  ascon_rnd   rnd,
    input  ascon_state current_state,
    output ascon_state next_state
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = current_state[319:256];
        x1 = current_state[255:192];
        // Round constant is ((15-i)<<4)|i, i.e. {~i, i} for a 4-bit index.
        x2 = current_state[191:128] ^ {56'h0, ~rnd, rnd};
        x3 = current_state[127:64];
        x4 = current_state[63:0];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);

        next_state = {x0, x1, x2, x3, x4};
    end

endmodule
`default_nettype wire

// File: rtl/ascon_round_engine.sv
`default_nettype none
// ascon_round_engine: sequential p^12 / p^8 driver, UNROLL chained rounds per clock, valid/ready in and out.
// Rev 1.0
module ascon_round_engine
    import ascon_aead128_pkg::*;
#(
    parameter int UNROLL = 1
)(
    input  logic                       clk,
    input  logic                       rst_n,
    ascon_round_engine_if.slave        bus
);

    generate
        if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4)) ||
            (ROUNDS_A % UNROLL != 0) || (ROUNDS_B % UNROLL != 0)) begin : g_bad_unroll
            $error("ascon_round_engine: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    engine_fsm  fsm, fsm_next;
    ascon_rnd   rnd, rnd_next;
    ascon_state state_reg, state_next;
    ascon_state chain [UNROLL+1];

    assign chain[0] = state_reg;

    generate
        for (genvar k = 0; k < UNROLL; k++) begin : g_round
            ascon_round_engine_perm u_perm (
                .rnd           (rnd + 4'(k)),
                .current_state (chain[k]),
                .next_state    (chain[k+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
        end else begin
            fsm       <= fsm_next;
            rnd       <= rnd_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        fsm_next   = fsm;
        rnd_next   = rnd;
        state_next = state_reg;
        case (fsm)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = bus.state_in;
                    // p^8 is the tail of p^12, so it simply starts later in the schedule.
                    rnd_next   = bus.pb_sel ? 4'(ROUNDS_A - ROUNDS_B) : 4'd0;
                    fsm_next   = RUN;
                end
            end
            RUN: begin
                state_next = chain[UNROLL];
                rnd_next   = rnd + 4'(UNROLL);
                if (rnd + 4'(UNROLL - 1) == 4'(ROUND_LAST)) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (fsm == IDLE);
    assign bus.out_valid = (fsm == DONE);
    assign bus.state_out = state_reg;

endmodule
`default_nettype wire

// File: tb/tb_ascon_round_engine.sv
`default_nettype none
// tb_ascon_round_engine: UNROLL=1/2/4 engines driven in lockstep and scored against an S-box-table Ascon model.
// Rev 1.0
module tb_ascon_round_engine;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int UN [3] = '{1, 2, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv = 1'b0;
    logic         sel = 1'b0;
    logic         ordy = 1'b1;
    logic [319:0] sin = '0;
    logic         ov [3];
    logic         ir [3];
    logic [319:0] so [3];

    int errors = 0;
    int checks = 0;
    logic [319:0] exp_q [$];

    ascon_round_engine_if b1 ();
    ascon_round_engine_if b2 ();
    ascon_round_engine_if b4 ();

    assign b1.in_valid = iv;  assign b1.pb_sel = sel;  assign b1.state_in = sin;  assign b1.out_ready = ordy;
    assign b2.in_valid = iv;  assign b2.pb_sel = sel;  assign b2.state_in = sin;  assign b2.out_ready = ordy;
    assign b4.in_valid = iv;  assign b4.pb_sel = sel;  assign b4.state_in = sin;  assign b4.out_ready = ordy;
    assign ov[0] = b1.out_valid;  assign ir[0] = b1.in_ready;  assign so[0] = b1.state_out;
    assign ov[1] = b2.out_valid;  assign ir[1] = b2.in_ready;  assign so[1] = b2.state_out;
    assign ov[2] = b4.out_valid;  assign ir[2] = b4.in_ready;  assign so[2] = b4.state_out;

    ascon_round_engine #(.UNROLL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ascon_round_engine #(.UNROLL(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    ascon_round_engine #(.UNROLL(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    function automatic logic [63:0] tb_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] g_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
        x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[col];
            for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
        end
        y[0] = y[0] ^ tb_ror(y[0], 19) ^ tb_ror(y[0], 28);
        y[1] = y[1] ^ tb_ror(y[1], 61) ^ tb_ror(y[1], 39);
        y[2] = y[2] ^ tb_ror(y[2], 1)  ^ tb_ror(y[2], 6);
        y[3] = y[3] ^ tb_ror(y[3], 10) ^ tb_ror(y[3], 17);
        y[4] = y[4] ^ tb_ror(y[4], 7)  ^ tb_ror(y[4], 41);
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] golden(input logic [319:0] s, input logic p8);
        logic [319:0] t = s;
        for (int r = (p8 ? 4 : 0); r < 12; r++) t = g_round(t, r);
        return t;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
        return r;
    endfunction

    task automatic issue(input logic p8, input logic [319:0] st);
        @(negedge clk);
        sel = p8;
        sin = st;
        iv  = 1'b1;
        exp_q.push_back(golden(st, p8));
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    task automatic test_reset();
        #22 rst_n = 1'b1;
        issue(1'b0, rand320());
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready u%0d: got %b want 1", UN[d], ir[d]); end
            checks++;
            if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid u%0d: got %b want 0", UN[d], ov[d]); end
            checks++;
            if (so[d] !== '0) begin errors++; $display("FAIL reset_state_out u%0d: got %h want 0", UN[d], so[d]); end
        end
        exp_q.delete();
        #3 rst_n = 1'b1;
    endtask

    task automatic test_p12();
        logic [319:0] exp_s;
        logic         seen [3];
        for (int n = 0; n < 2; n++) begin
            issue(1'b0, (n == 0) ? 320'h0 : rand320());
            exp_s = exp_q.pop_front();
            seen = '{1'b0, 1'b0, 1'b0};
            for (int cyc = 1; cyc <= 16; cyc++) begin
                @(posedge clk); #1;
                for (int d = 0; d < 3; d++) begin
                    if (!seen[d] && ov[d]) begin
                        seen[d] = 1'b1;
                        checks++;
                        if (cyc != 12 / UN[d]) begin errors++; $display("FAIL p12_latency u%0d: got %0d want %0d", UN[d], cyc, 12 / UN[d]); end
                        checks++;
                        if (so[d] !== exp_s) begin errors++; $display("FAIL p12_result u%0d: got %h want %h", UN[d], so[d], exp_s); end
                    end
                end
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (!seen[d]) begin errors++; $display("FAIL p12_timeout u%0d: out_valid got 0 want 1", UN[d]); end
            end
        end
    endtask

    task automatic test_p8();
        logic [319:0] exp_s;
        logic         seen [3];
        issue(1'b1, {64'h00001000808c0001, 256'h0});
        exp_s = exp_q.pop_front();
        seen = '{1'b0, 1'b0, 1'b0};
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1;
                    checks++;
                    if (cyc != 8 / UN[d]) begin errors++; $display("FAIL p8_latency u%0d: got %0d want %0d", UN[d], cyc, 8 / UN[d]); end
                    checks++;
                    if (so[d] !== exp_s) begin errors++; $display("FAIL p8_result u%0d: got %h want %h", UN[d], so[d], exp_s); end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (!seen[d]) begin errors++; $display("FAIL p8_timeout u%0d: out_valid got 0 want 1", UN[d]); end
        end
    endtask

    task automatic test_backpressure();
        logic [319:0] st;
        logic [319:0] exp_s;
        st = rand320();
        @(negedge clk);
        ordy = 1'b0;
        issue(1'b0, st);
        exp_s = exp_q.pop_front();
        repeat (12) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b1) begin errors++; $display("FAIL bp_reach_done u%0d: out_valid got %b want 1", UN[d], ov[d]); end
        end
        @(negedge clk);
        iv  = 1'b1;
        sel = 1'b1;
        sin = ~st;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || so[d] !== exp_s) begin
                    errors++;
                    $display("FAIL bp_hold u%0d c%0d: got ov=%b ir=%b so=%h want ov=1 ir=0 so=%h", UN[d], c, ov[d], ir[d], so[d], exp_s);
                end
            end
        end
        @(negedge clk);
        iv   = 1'b0;
        ordy = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
                errors++;
                $display("FAIL bp_release u%0d: got ov=%b ir=%b want ov=0 ir=1", UN[d], ov[d], ir[d]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [319:0] exp_s;
        logic         stale [3];
        logic         seen [3];
        issue(1'b0, rand320());
        exp_q.delete();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        stale = '{1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (ov[d]) stale[d] = 1'b1;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (stale[d]) begin errors++; $display("FAIL midrun_stale u%0d: out_valid pulse got 1 want 0", UN[d]); end
        end
        issue(1'b1, rand320());
        exp_s = exp_q.pop_front();
        seen = '{1'b0, 1'b0, 1'b0};
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1;
                    checks++;
                    if (cyc != 8 / UN[d] || so[d] !== exp_s) begin
                        errors++;
                        $display("FAIL midrun_p8 u%0d: got lat=%0d so=%h want lat=%0d so=%h", UN[d], cyc, so[d], 8 / UN[d], exp_s);
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (!seen[d]) begin errors++; $display("FAIL midrun_timeout u%0d: out_valid got 0 want 1", UN[d]); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_p12();
        test_p8();
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
